// File: rtl/alu_share_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared types for the ALU and its sharing arbiter.
//   alu_op_t    : 3-bit ALU operation code
//   ALU_*       : the operation codes the ALU implements; other codes
//                 make the ALU return result 0 and EQ 0
//   arb_state_t : arbiter FSM states
// ---------------------------------------------------------------------------
package alu_pkg;

    typedef logic [2:0] alu_op_t;

    localparam alu_op_t ALU_ADD = 3'b000;
    localparam alu_op_t ALU_SUB = 3'b001;
    localparam alu_op_t ALU_AND = 3'b010;
    localparam alu_op_t ALU_XOR = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/alu_share_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational round-robin priority select: returns the first asserted
// bit of valid at or after ptr, wrapping modulo NREQ.
//   valid     : request vector
//   ptr       : highest-priority index this cycle (must be < NREQ)
//   grant_oh  : one-hot winner, zero when nothing is valid
//   grant_idx : winner index, 0 when nothing is valid
//   found     : some bit of valid is set
// ---------------------------------------------------------------------------
module rr_picker #(
    parameter int NREQ  = 2,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant_oh,
    output logic [IDX_W-1:0] grant_idx,
    output logic             found
);

    // cand_idx[k] is the index examined at priority rank k.
    logic [IDX_W-1:0] cand_idx [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_cand
            localparam logic [IDX_W:0] OFFSET = (IDX_W+1)'(gi);
            localparam logic [IDX_W:0] LIMIT  = (IDX_W+1)'(NREQ);
            logic [IDX_W:0] sum;
            // ptr < NREQ, so one conditional subtract is enough to wrap.
            assign sum          = {1'b0, ptr} + OFFSET;
            assign cand_idx[gi] = (sum >= LIMIT) ? IDX_W'(sum - LIMIT) : sum[IDX_W-1:0];
        end
    endgenerate

    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && valid[cand_idx[i]]) begin
                found     = 1'b1;
                grant_idx = cand_idx[i];
            end
        end
        grant_oh = '0;
        if (found) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
// Shares one combinational ALU between NREQ requesters. A round-robin winner
// is accepted (req_ready), its operands are registered onto the ALU inputs,
// the ALU outputs are captured one cycle later, and the response is held on
// the shared result bus until the owning requester takes it.
//   clk, rst_n              : clock, asynchronous active-low reset
//   req_valid/req_ready     : per-requester request handshake
//   req_SrcA/SrcB/ALUctrl   : packed per-requester operands and op
//   rsp_valid/rsp_ready     : per-requester response handshake
//   rsp_ALUResult/rsp_EQ    : registered result and equality flag
//   SrcA/SrcB/ALUctrl       : registered drive to the ALU
//   ALUResult/EQ            : ALU outputs
//   busy                    : arbiter not idle
// ---------------------------------------------------------------------------
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREQ  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_SrcA,
    input  logic [NREQ*WIDTH-1:0] req_SrcB,
    input  logic [NREQ*3-1:0]     req_ALUctrl,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]      rsp_ALUResult,
    output logic                  rsp_EQ,
    output logic [WIDTH-1:0]      SrcA,
    output logic [WIDTH-1:0]      SrcB,
    output logic [2:0]            ALUctrl,
    input  logic [WIDTH-1:0]      ALUResult,
    input  logic                  EQ,
    output logic                  busy
);

    localparam int IDX_W = $clog2(NREQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);

    arb_state_t       state_q,    state_d;
    logic [IDX_W-1:0] rr_ptr_q,   rr_ptr_d;
    logic [IDX_W-1:0] grant_q,    grant_d;
    logic [WIDTH-1:0] src_a_q,    src_a_d;
    logic [WIDTH-1:0] src_b_q,    src_b_d;
    alu_op_t          alu_ctrl_q, alu_ctrl_d;
    logic [WIDTH-1:0] result_q,   result_d;
    logic             eq_q,       eq_d;
    logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic             busy_q,     busy_d;

    // Unpacked views of the per-requester operand buses.
    logic [WIDTH-1:0] op_a   [NREQ];
    logic [WIDTH-1:0] op_b   [NREQ];
    alu_op_t          op_ctl [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign op_a[gi]   = req_SrcA[gi*WIDTH +: WIDTH];
            assign op_b[gi]   = req_SrcB[gi*WIDTH +: WIDTH];
            assign op_ctl[gi] = req_ALUctrl[gi*3 +: 3];
        end
    endgenerate

    logic             accept_rsp;
    logic [IDX_W-1:0] next_ptr;
    logic [IDX_W-1:0] pick_ptr;
    logic [NREQ-1:0]  pick_oh;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic             take;

    // When the held response is taken, the pointer moves past its owner in
    // the same cycle so a back-to-back grant already sees the new priority.
    assign accept_rsp = (state_q == RESP) && rsp_ready[grant_q];
    assign next_ptr   = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
    assign pick_ptr   = accept_rsp ? next_ptr : rr_ptr_q;

    rr_picker #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .valid     (req_valid),
        .ptr       (pick_ptr),
        .grant_oh  (pick_oh),
        .grant_idx (pick_idx),
        .found     (pick_found)
    );

    assign take      = pick_found && ((state_q == IDLE) || accept_rsp);
    assign req_ready = take ? pick_oh : '0;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        src_a_d    = src_a_q;
        src_b_d    = src_b_q;
        alu_ctrl_d = alu_ctrl_q;
        result_d   = result_q;
        eq_d       = eq_q;

        case (state_q)
            EXEC: begin
                result_d = ALUResult;
                eq_d     = EQ;
                state_d  = RESP;
            end
            RESP: begin
                if (accept_rsp) begin
                    rr_ptr_d = next_ptr;
                    state_d  = IDLE;
                end
            end
            default: ;
        endcase

        // ALU-drive registers only change on a grant, so they hold in IDLE.
        if (take) begin
            grant_d    = pick_idx;
            src_a_d    = op_a[pick_idx];
            src_b_d    = op_b[pick_idx];
            alu_ctrl_d = op_ctl[pick_idx];
            state_d    = EXEC;
        end

        rsp_valid_d = '0;
        if (state_d == RESP) begin
            rsp_valid_d[grant_d] = 1'b1;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            src_a_q     <= '0;
            src_b_q     <= '0;
            alu_ctrl_q  <= ALU_ADD;
            result_q    <= '0;
            eq_q        <= 1'b0;
            rsp_valid_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            src_a_q     <= src_a_d;
            src_b_q     <= src_b_d;
            alu_ctrl_q  <= alu_ctrl_d;
            result_q    <= result_d;
            eq_q        <= eq_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign SrcA          = src_a_q;
    assign SrcB          = src_b_q;
    assign ALUctrl       = alu_ctrl_q;
    assign rsp_ALUResult = result_q;
    assign rsp_EQ        = eq_q;
    assign rsp_valid     = rsp_valid_q;
    assign busy          = busy_q;

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares the single ALU instance between NREQ requesters (e.g. execute datapath, branch-compare unit, address-generation helper) using per-requester valid/ready request and response channels. Round-robin arbitration picks one request, registers its operands into the ALU, captures ALUResult/EQ, and holds the response until the owning requester accepts it. Sits between the requesters and the alu module; the ALU itself stays purely combinational.

Parameters:
WIDTH, 32, operand/result width; must match the alu WIDTH
NREQ, 2, number of requesters (2..4)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NREQ  per-requester request valid
req_ready  output  NREQ  per-requester request accepted this cycle
req_SrcA  input  NREQ*WIDTH  operand A per requester
req_SrcB  input  NREQ*WIDTH  operand B per requester
req_ALUctrl  input  NREQ*3  ALU op per requester
rsp_valid  output  NREQ  response valid, one-hot or zero
rsp_ready  input  NREQ  per-requester response accept
rsp_ALUResult  output  WIDTH  registered result, shared bus
rsp_EQ  output  1  registered equality flag
SrcA  output  WIDTH  to alu
SrcB  output  WIDTH  to alu
ALUctrl  output  3  to alu
ALUResult  input  WIDTH  from alu
EQ  input  1  from alu
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (rst_n low, async): state=IDLE; req_ready=0, rsp_valid=0, rsp_ALUResult=0, rsp_EQ=0, SrcA=SrcB=0, ALUctrl=3'b000, busy=0, rr pointer=0, grant index=0. An in-flight operation is discarded; no response is produced for it.
- States: IDLE, EXEC, RESP.
- IDLE: if any req_valid, select winner = first valid index at or after rr pointer (wrapping modulo NREQ). req_ready[winner]=1 combinationally that cycle (only one bit ever high). On the clock edge latch winner's SrcA/SrcB/ALUctrl into the ALU-drive registers, store grant index, go EXEC. No valid: stay IDLE, req_ready=0.
- EXEC: ALU-drive registers stable; on the edge capture ALUResult and EQ into rsp_ALUResult/rsp_EQ, go RESP.
- RESP: rsp_valid[grant]=1, all other bits 0; result and EQ held stable. When rsp_ready[grant]=1: rr pointer <= (grant+1) mod NREQ. If any req_valid is present in that same cycle, arbitrate with the updated pointer (computed combinationally), assert req_ready to the new winner, latch it, and go directly to EXEC (back-to-back). Otherwise go IDLE. rsp_ready on non-granted bits is ignored.
- Latency: request accepted in cycle N -> rsp_valid in cycle N+2; sustained throughput of 1 op per 2 cycles when responses are accepted immediately.
- Requesters hold operands stable while req_valid=1 and req_ready=0; dropping req_valid before acceptance is legal and causes no grant.
- ALU ops are passed through unmodified (000 add, 001 sub, 010 and, 100 xor, others -> result 0, EQ 0 per alu). Arithmetic wraps modulo 2^WIDTH inside alu; the arbiter performs no arithmetic on data.
- Fairness: a continuously asserting requester cannot be granted twice in a row while another requester is valid.
- ALU-drive registers keep their last values in IDLE (no toggling to 0) to avoid needless switching.

Decomposition:
- Shared package alu_pkg: typedef alu_op_t (3-bit) and constants ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_XOR=3'b100; state enum arb_state_t {IDLE, EXEC, RESP}.
- One sub-module: rr_picker (combinational round-robin priority select; inputs valid vector and pointer; outputs one-hot grant and index), instantiated once.

Test Plan:
- Reset mid-op: accept req0 add(5,7), assert rst_n=0 during EXEC -> all outputs 0, state IDLE, no rsp_valid after release.
- Single request: req0 add(32'hFFFF_FFFF, 1) -> req_ready[0] in cycle N, rsp_valid[0] in cycle N+2, rsp_ALUResult=0, rsp_EQ=0.
- Simultaneous: req0 sub(9,9) and req1 xor(0xF0,0x0F) both valid after reset -> req0 served first (result 0, EQ=1), then req1 (0xFF, EQ=0).
- Fairness: req0 and req1 held valid continuously for 8 ops -> grants strictly alternate 0,1,0,1…
- Response backpressure: rsp_ready[1]=0 for 5 cycles -> rsp_valid[1] and result stay stable, req_ready all 0, busy=1; a stray rsp_ready[0] is ignored.
- Back-to-back plus illegal op: req0 and(0xF0F0,0xFF00) accepted the same cycle the previous response is accepted -> EXEC entered directly, result 0xF000; an op of 3'b111 -> result 0, EQ 0.
